alu_share_arbiter: RTL and testbench

//  Shares one 64-bit Y86 ALU datapath (add/sub/and/xor) between NUM_REQ requesters, e.g. execute stage and address-calc logic.

---
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin shared 64-bit Y86 ALU (add/sub/and/xor) for NUM_REQ requesters.
// One op in flight: IDLE grants, EXEC computes, RESP holds result+ZF/SF/OF until the owner accepts.
module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int WIDTH   = 64,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*2-1:0]     req_fun_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic                     rsp_zf_o,
  output logic                     rsp_sf_o,
  output logic                     rsp_of_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam logic [1:0] FN_ADD = 2'd0, FN_SUB = 2'd1, FN_AND = 2'd2, FN_XOR = 2'd3;

  state_e            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d, gnt_q, gnt_idx;
  logic              gnt_any;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic [1:0]        fun_q;
  logic              zf_q, sf_q, of_q;

  // Packed views: element i lines up with slice i of the flat ports.
  logic [NUM_REQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NUM_REQ-1:0][1:0]       fun_arr;
  assign a_arr   = req_a_i;
  assign b_arr   = req_b_i;
  assign fun_arr = req_fun_i;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [GW-1:0] k;
      k = GW'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_any && req_valid_i[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
  end

  // ALU
  logic [WIDTH-1:0] b_op, sum, alu_r;
  logic             alu_of;
  always_comb begin
    b_op   = (fun_q == FN_SUB) ? ~b_q : b_q;
    sum    = a_q + b_op + {{(WIDTH-1){1'b0}}, (fun_q == FN_SUB)};
    alu_r  = sum;
    alu_of = 1'b0;
    unique case (fun_q)
      FN_ADD: alu_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      FN_SUB: alu_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      FN_AND: alu_r  = a_q & b_q;
      FN_XOR: alu_r  = a_q ^ b_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: if (gnt_any) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i[gnt_q]) begin
        state_d = IDLE;
        ptr_d   = (gnt_q == GW'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; rst_n gate keeps req_ready low while reset is held with requests pending.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    busy_o      = (state_q != IDLE);
    if (state_q == IDLE && gnt_any && rst_n) req_ready_o = NUM_REQ'(1) << gnt_idx;
    if (state_q == RESP)                     rsp_valid_o = NUM_REQ'(1) << gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      fun_q <= '0;
      res_q <= '0;
      zf_q  <= 1'b0;
      sf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_any) begin
        gnt_q <= gnt_idx;
        a_q   <= a_arr[gnt_idx];
        b_q   <= b_arr[gnt_idx];
        fun_q <= fun_arr[gnt_idx];
      end
      if (state_q == EXEC) begin
        res_q <= alu_r;
        zf_q  <= (alu_r == '0);
        sf_q  <= alu_r[WIDTH-1];
        of_q  <= alu_of;
      end
    end
  end

  assign rsp_result_o = res_q;
  assign rsp_zf_o     = zf_q;
  assign rsp_sf_o     = sf_q;
  assign rsp_of_o     = of_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter against a behavioural ALU/round-robin model.
module tb_alu_share_arbiter;
  localparam int N = 2;
  localparam int W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      rv, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]    req_a, req_b;
  logic [N*2-1:0]    req_fun;
  logic [W-1:0]      rsp_result;
  logic              rsp_zf, rsp_sf, rsp_of, busy;
  logic [W-1:0]      ra [N];
  logic [W-1:0]      rb [N];
  logic [1:0]        rf [N];

  int vectors = 0;
  int miscompares = 0;
  int ptr = 0;
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_a[i*W +: W] = ra[i];
    assign req_b[i*W +: W] = rb[i];
    assign req_fun[i*2 +: 2] = rf[i];
  end

  alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(rv), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_fun_i(req_fun),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zf_o(rsp_zf), .rsp_sf_o(rsp_sf), .rsp_of_o(rsp_of),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: sign-extended 65-bit arithmetic; overflow when the two top bits disagree.
  task automatic ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                         output logic [63:0] r, output logic z, output logic s, output logic o);
    logic [64:0] wide;
    case (f)
      2'd0:    wide = {a[63], a} + {b[63], b};
      2'd1:    wide = {a[63], a} - {b[63], b};
      2'd2:    wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    r = wide[63:0];
    z = (r == 64'd0);
    s = r[63];
    o = (f < 2'd2) ? (wide[64] != wide[63]) : 1'b0;
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] m;
    m = '0;
    m[g] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete op: grant, EXEC, RESP with `hold` cycles of backpressure, accept.
  task automatic serve(input int hold, input bit keep);
    int g;
    logic [63:0] er;
    logic ez, es, eo;
    #1;
    g = exp_grant(rv, ptr);
    chk("grant", req_ready, onehot(g));
    chk("busy_idle", busy, 0);
    ref_alu(ra[g], rb[g], rf[g], er, ez, es, eo);
    tick();
    if (!keep) rv[g] = 1'b0;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_rspv", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    tick();
    chk("rsp_valid", rsp_valid, onehot(g));
    chk("result", rsp_result, er);
    chk("zf", rsp_zf, ez);
    chk("sf", rsp_sf, es);
    chk("of", rsp_of, eo);
    last_res = rsp_result;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = N'($urandom);
      rsp_ready[g] = 1'b0;
      tick();
      chk("hold_rspv", rsp_valid, onehot(g));
      chk("hold_result", rsp_result, er);
      chk("hold_flags", {rsp_zf, rsp_sf, rsp_of}, {ez, es, eo});
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = N'($urandom);
    rsp_ready[g] = 1'b1;
    tick();
    rsp_ready = '0;
    ptr = (g + 1) % N;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = '0;
    rv = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rf[i] = '0; end

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      rv = N'($urandom);
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[i] = {$urandom, $urandom}; rb[i] = {$urandom, $urandom}; rf[i] = 2'($urandom);
      end
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", {rsp_zf, rsp_sf, rsp_of}, 0);
      chk("rst_busy", busy, 0);
    end
    rv = '0;
    rsp_ready = '0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_rspv", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);

    // Req0 SUB 5-7
    ra[0] = 64'd5; rb[0] = 64'd7; rf[0] = 2'd1; rv = 2'b01;
    serve(0, 1'b0);
    chk("t2_lit_res", last_res, 64'hFFFF_FFFF_FFFF_FFFE);

    // Req1 signed overflow cases
    ra[1] = 64'h8000_0000_0000_0000; rb[1] = 64'd1; rf[1] = 2'd1; rv = 2'b10;
    serve(0, 1'b0);
    chk("t3_lit_sub", last_res, 64'h7FFF_FFFF_FFFF_FFFF);
    ra[1] = 64'h7FFF_FFFF_FFFF_FFFF; rb[1] = 64'h7FFF_FFFF_FFFF_FFFF; rf[1] = 2'd0; rv = 2'b10;
    serve(1, 1'b0);
    chk("t3_lit_add", last_res, 64'hFFFF_FFFF_FFFF_FFFE);

    // Both requesters continuously valid: grants alternate 0,1,0,1
    for (int i = 0; i < N; i++) begin ra[i] = 64'd1; rb[i] = 64'd1; rf[i] = 2'd0; end
    rv = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_alt", req_ready, onehot(k % 2));
      serve(0, 1'b1);
      chk("t4_lit_res", last_res, 64'd2);
    end
    rv = '0;

    // Backpressure on req0 XOR a=b while req1 waits
    ra[0] = 64'h1234_5678_9ABC_DEF0; rb[0] = 64'h1234_5678_9ABC_DEF0; rf[0] = 2'd3;
    ra[1] = 64'd10; rb[1] = 64'd3; rf[1] = 2'd2;
    rv = 2'b01;
    #1;
    rv = 2'b11;
    serve(5, 1'b0);
    #1;
    chk("t5_next_ready", req_ready, 2'b10);
    serve(0, 1'b0);

    // Reset while in EXEC: op dropped, pointer back to 0
    rf[0] = 2'd0; rv = 2'b01;
    serve(0, 1'b0);
    rv = 2'b10;
    tick();
    rv = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 0);
    #2;
    rst_n = 1'b1;
    ptr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_no_rsp", rsp_valid, 0);
    end
    rv = 2'b11;
    #1;
    chk("t6_grant0", req_ready, 2'b01);
    serve(0, 1'b0);
    serve(0, 1'b0);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) begin
          ra[i] = {$urandom, $urandom};
          rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : {$urandom, $urandom};
          rf[i] = 2'($urandom);
          rv[i] = 1'($urandom);
        end
      end
      if (rv == '0) rv[$urandom_range(0, N - 1)] = 1'b1;
      serve($urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
